// File: rtl/t01_ai_pkg.sv
// Shared definitions for the Tetris AI candidate sweep: piece type codes,
// per-family rotation tables and the footprint width of each type.
package t01_ai_pkg;

    localparam int BOARD_W_DEFAULT = 10;
    localparam int TYPE_W          = 5;
    localparam int FAM_W           = 3;

    typedef enum logic [TYPE_W-1:0] {
        T_I_H = 5'd0, T_I_V, T_O, T_S_H, T_S_V, T_Z_H, T_Z_V,
        T_L_0, T_L_1, T_L_2, T_L_3,
        T_J_0, T_J_1, T_J_2, T_J_3,
        T_T_0, T_T_1, T_T_2, T_T_3
    } type_code_e;

    typedef enum logic [FAM_W-1:0] {
        FAM_I, FAM_O, FAM_S, FAM_Z, FAM_L, FAM_J, FAM_T, FAM_BAD
    } family_e;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ISSUE, S_WAIT, S_ADVANCE, S_DONE
    } state_e;

    // The invalid family maps to an empty rotation set.
    localparam logic [TYPE_W-1:0] FAMILY_BASE [8] = '{
        5'd0, 5'd2, 5'd3, 5'd5, 5'd7, 5'd11, 5'd15, 5'd0
    };
    localparam logic [2:0] FAMILY_ROTS [8] = '{
        3'd2, 3'd1, 3'd2, 3'd2, 3'd4, 3'd4, 3'd4, 3'd0
    };

    function automatic logic [2:0] type_width(input logic [TYPE_W-1:0] t);
        logic [2:0] w;
        case (t)
            T_I_H:               w = 3'd4;
            T_I_V:               w = 3'd1;
            T_O, T_S_V, T_Z_V:   w = 3'd2;
            T_S_H, T_Z_H:        w = 3'd3;
            // L, J and T alternate flat (odd code, width 3) and upright (width 2).
            default:             w = t[0] ? 3'd3 : 3'd2;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/t01_ai_move_enum_if.sv
// MMU scoring handshake plus the candidate placement it is scoring; the
// best-move stage snoops the same bundle.
interface t01_ai_move_enum_if;
    import t01_ai_pkg::*;

    logic              mmu_start_o;
    logic              mmu_done_i;
    logic [3:0]        blockX_o;
    logic [TYPE_W-1:0] block_type_o;

    modport master (
        output mmu_start_o, blockX_o, block_type_o,
        input  mmu_done_i
    );

    modport slave (
        input  mmu_start_o, blockX_o, block_type_o,
        output mmu_done_i
    );

endinterface

// File: rtl/t01_ai_piece_lut.sv
// Combinational piece tables: type code to footprint width, family to
// (base type code, rotation count).
module t01_ai_piece_lut
    import t01_ai_pkg::*;
(
    input  logic [TYPE_W-1:0] type_i,
    input  logic [FAM_W-1:0]  family_i,
    output logic [2:0]        width_o,
    output logic [TYPE_W-1:0] base_o,
    output logic [2:0]        rot_count_o
);

    assign width_o     = type_width(type_i);
    assign base_o      = FAMILY_BASE[family_i];
    assign rot_count_o = FAMILY_ROTS[family_i];

endmodule

// File: rtl/t01_ai_move_enum.sv
// Candidate-placement sequencer: walks every legal (rotation, column) of a
// spawned piece family and issues one MMU scoring request per candidate.
module t01_ai_move_enum
    import t01_ai_pkg::*;
#(
    parameter int BOARD_W     = BOARD_W_DEFAULT,
    parameter int MMU_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [FAM_W-1:0]   family_i,
    t01_ai_move_enum_if.master mmu,
    output logic               ofm_clear_o,
    output logic               busy_o,
    output logic               sweep_done_o,
    output logic               err_o
);

    localparam int               CNT_W       = (MMU_TIMEOUT < 2) ? 1 : $clog2(MMU_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MMU_TIMEOUT);
    localparam logic [3:0]       BOARD_W_X   = 4'(BOARD_W);

    state_e             state_q;
    logic [FAM_W-1:0]   family_q;
    logic [3:0]         x_q;
    logic [1:0]         rot_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               mmu_start_q;
    logic               ofm_clear_q;
    logic               busy_q;
    logic               sweep_done_q;
    logic               err_q;

    logic [2:0]         width_d;
    logic [TYPE_W-1:0]  base_d;
    logic [2:0]         rot_count_d;
    logic [TYPE_W-1:0]  type_d;
    logic [3:0]         x_limit_d;
    logic               x_last_d;
    logic               rot_last_d;

    t01_ai_piece_lut u_lut (
        .type_i      (type_d),
        .family_i    (family_q),
        .width_o     (width_d),
        .base_o      (base_d),
        .rot_count_o (rot_count_d)
    );

    assign type_d     = base_d + TYPE_W'(rot_q);
    assign x_limit_d  = BOARD_W_X - {1'b0, width_d};
    assign x_last_d   = (x_q >= x_limit_d);
    assign rot_last_d = (({1'b0, rot_q} + 3'd1) >= rot_count_d);

    // x_q/rot_q only move on the edge that enters ISSUE, so the placement
    // stays frozen for the whole scoring window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            family_q     <= '0;
            x_q          <= '0;
            rot_q        <= '0;
            cnt_q        <= '0;
            mmu_start_q  <= 1'b0;
            ofm_clear_q  <= 1'b0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; these defaults make every pulse one cycle wide.
            mmu_start_q  <= 1'b0;
            ofm_clear_q  <= 1'b0;
            sweep_done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start_i) begin
                    family_q <= family_i;
                    x_q      <= '0;
                    rot_q    <= '0;
                    busy_q   <= 1'b1;
                    if (family_i == FAM_BAD) begin
                        err_q        <= 1'b1;
                        sweep_done_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        err_q       <= 1'b0;
                        ofm_clear_q <= 1'b1;
                        state_q     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    x_q         <= '0;
                    rot_q       <= '0;
                    cnt_q       <= '0;
                    mmu_start_q <= 1'b1;
                    state_q     <= S_ISSUE;
                end
                S_ISSUE: begin
                    cnt_q   <= cnt_q + CNT_W'(1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A response in the timeout cycle still counts as a result.
                    if (mmu.mmu_done_i) begin
                        state_q <= S_ADVANCE;
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        err_q   <= 1'b1;
                        state_q <= S_ADVANCE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_ADVANCE: begin
                    if (!x_last_d) begin
                        x_q         <= x_q + 4'd1;
                        cnt_q       <= '0;
                        mmu_start_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end else if (rot_last_d) begin
                        sweep_done_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        x_q         <= '0;
                        rot_q       <= rot_q + 2'd1;
                        cnt_q       <= '0;
                        mmu_start_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mmu.mmu_start_o  = mmu_start_q;
    assign mmu.blockX_o     = x_q;
    assign mmu.block_type_o = type_d;
    assign ofm_clear_o      = ofm_clear_q;
    assign busy_o           = busy_q;
    assign sweep_done_o     = sweep_done_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_t01_ai_move_enum.sv
// Directed bench for the candidate sweep: behavioural MMU with settable
// latency / dropped candidate, an output monitor, and one task per scenario.
module tb_t01_ai_move_enum;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [2:0] family_i;
    logic       ofm_clear;
    logic       busy;
    logic       sweep_done;
    logic       err;

    logic resp_done = 1'b0;
    logic spur_done = 1'b0;
    logic resp_en   = 1'b1;
    int   resp_lat  = 1;
    int   resp_cnt  = 0;
    int   skip_abs  = 0;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state
    int         ncyc = 0;
    int         start_cnt = 0;
    int         done_cnt = 0;
    int         clr_cnt = 0;
    int         stab_err = 0;
    int         err_rise_cyc = 0;
    int         skip_start_cyc = 0;
    logic [4:0] type_q [$];
    logic [3:0] x_q [$];
    logic [4:0] held_t;
    logic [3:0] held_x;
    logic       in_cand = 1'b0;
    logic       err_prev = 1'b0;

    t01_ai_move_enum_if mif ();

    assign mif.mmu_done_i = resp_done | spur_done;

    t01_ai_move_enum #(.BOARD_W(10), .MMU_TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .family_i     (family_i),
        .mmu          (mif),
        .ofm_clear_o  (ofm_clear),
        .busy_o       (busy),
        .sweep_done_o (sweep_done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    // MMU model: answers each request resp_lat cycles after its ISSUE cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mif.mmu_start_o === 1'b1) begin
                resp_cnt++;
                if (resp_cnt != skip_abs) begin
                    repeat (resp_lat) @(negedge clk);
                    if (resp_en) resp_done = 1'b1;
                    @(negedge clk);
                    resp_done = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            ncyc++;
            if (mif.mmu_start_o === 1'b1) begin
                start_cnt++;
                type_q.push_back(mif.block_type_o);
                x_q.push_back(mif.blockX_o);
                held_t  = mif.block_type_o;
                held_x  = mif.blockX_o;
                in_cand = 1'b1;
                if (start_cnt == skip_abs) skip_start_cyc = ncyc;
            end else if (in_cand && (mif.blockX_o !== held_x || mif.block_type_o !== held_t)) begin
                stab_err++;
            end
            if (busy !== 1'b1) in_cand = 1'b0;
            if (sweep_done === 1'b1) done_cnt++;
            if (ofm_clear === 1'b1) clr_cnt++;
            if (err === 1'b1 && err_prev !== 1'b1) err_rise_cyc = ncyc;
            err_prev = err;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inclusive cycle count: the start_i cycle is 1, the sweep_done cycle is the last.
    task automatic run_sweep(input logic [2:0] fam, input int lat, input int skip, input int inject,
                             output int cyc, output logic busy_n1, output logic err_n1,
                             output logic clr_n1);
        resp_lat = lat;
        skip_abs = (skip > 0) ? resp_cnt + skip : 0;
        busy_n1  = 1'b0;
        err_n1   = 1'b0;
        clr_n1   = 1'b0;
        @(negedge clk);
        start_i  = 1'b1;
        family_i = fam;
        cyc      = 1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                start_i  = 1'b0;
                family_i = 3'd0;
            end
            if (inject > 2 && cyc == inject)     start_i = 1'b1;
            if (inject > 2 && cyc == inject + 1) start_i = 1'b0;
            #2;
            if (cyc == 2) begin
                busy_n1 = busy;
                err_n1  = err;
                clr_n1  = ofm_clear;
            end
            if (sweep_done === 1'b1) break;
        end
        start_i = 1'b0;
        n_checks++;
        if (sweep_done !== 1'b1) $display("FAIL sweep_timeout: sweep_done=%b after %0d cycles, required 1", sweep_done, cyc);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; family_i = 3'd0;
        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if ({mif.mmu_start_o, mif.blockX_o, mif.block_type_o, ofm_clear, busy, sweep_done, err} !== 14'd0)
            $display("FAIL reset_in: outputs=%h required 0", {mif.mmu_start_o, mif.blockX_o, mif.block_type_o, ofm_clear, busy, sweep_done, err});
        else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        n_checks++;
        if ({mif.mmu_start_o, mif.blockX_o, mif.block_type_o, ofm_clear, busy, sweep_done, err} !== 14'd0)
            $display("FAIL reset_after: outputs=%h required 0", {mif.mmu_start_o, mif.blockX_o, mif.block_type_o, ofm_clear, busy, sweep_done, err});
        else n_pass++;
    endtask

    task automatic test_family_t();
        int cyc, b, s0, d0, c0, st0, et, ex;
        logic bn, en, cn;
        b = type_q.size(); s0 = start_cnt; d0 = done_cnt; c0 = clr_cnt; st0 = stab_err;
        run_sweep(3'd6, 3, 0, 0, cyc, bn, en, cn);
        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if (start_cnt - s0 != 34) $display("FAIL t_starts: got %0d required 34", start_cnt - s0); else n_pass++;
        for (int i = 0; i < 34 && b + i < type_q.size(); i++) begin
            if (i < 8)       begin et = 15; ex = i;      end
            else if (i < 17) begin et = 16; ex = i - 8;  end
            else if (i < 25) begin et = 17; ex = i - 17; end
            else             begin et = 18; ex = i - 25; end
            n_checks++;
            if (type_q[b+i] !== 5'(et) || x_q[b+i] !== 4'(ex))
                $display("FAIL t_cand%0d: type=%0d x=%0d required type=%0d x=%0d", i, type_q[b+i], x_q[b+i], et, ex);
            else n_pass++;
        end
        n_checks++;
        if (mif.blockX_o !== 4'd8) $display("FAIL t_final_x: got %0d required 8", mif.blockX_o); else n_pass++;
        n_checks++;
        if (cyc != 173) $display("FAIL t_latency: got %0d cycles required 173", cyc); else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL t_done_pulses: got %0d required 1", done_cnt - d0); else n_pass++;
        n_checks++;
        if (clr_cnt - c0 != 1 || cn !== 1'b1) $display("FAIL t_clear: pulses=%0d first=%b required 1,1", clr_cnt - c0, cn); else n_pass++;
        n_checks++;
        if (bn !== 1'b1 || busy !== 1'b0) $display("FAIL t_busy: during=%b after=%b required 1,0", bn, busy); else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL t_err: got %b required 0", err); else n_pass++;
        n_checks++;
        if (stab_err != st0) $display("FAIL t_stable: %0d changes inside scoring window, required 0", stab_err - st0); else n_pass++;
    endtask

    task automatic test_family_o_i();
        int cyc, b, s0;
        logic bn, en, cn;
        b = type_q.size(); s0 = start_cnt;
        run_sweep(3'd1, 1, 0, 0, cyc, bn, en, cn);
        n_checks++;
        if (start_cnt - s0 != 9 || cyc != 30) $display("FAIL o_count: starts=%0d cycles=%0d required 9,30", start_cnt - s0, cyc); else n_pass++;
        for (int i = 0; i < 9 && b + i < type_q.size(); i++) begin
            n_checks++;
            if (type_q[b+i] !== 5'd2 || x_q[b+i] !== 4'(i))
                $display("FAIL o_cand%0d: type=%0d x=%0d required type=2 x=%0d", i, type_q[b+i], x_q[b+i], i);
            else n_pass++;
        end
        b = type_q.size(); s0 = start_cnt;
        run_sweep(3'd0, 2, 0, 0, cyc, bn, en, cn);
        n_checks++;
        if (start_cnt - s0 != 17 || cyc != 71) $display("FAIL i_count: starts=%0d cycles=%0d required 17,71", start_cnt - s0, cyc); else n_pass++;
        for (int i = 0; i < 17 && b + i < type_q.size(); i++) begin
            n_checks++;
            if (type_q[b+i] !== ((i < 7) ? 5'd0 : 5'd1) || x_q[b+i] !== ((i < 7) ? 4'(i) : 4'(i - 7)))
                $display("FAIL i_cand%0d: type=%0d x=%0d required type=%0d x=%0d", i, type_q[b+i], x_q[b+i], (i < 7) ? 0 : 1, (i < 7) ? i : i - 7);
            else n_pass++;
        end
    endtask

    task automatic test_invalid_family();
        int cyc, s0, d0;
        logic bn, en, cn;
        s0 = start_cnt; d0 = done_cnt;
        run_sweep(3'd7, 1, 0, 0, cyc, bn, en, cn);
        repeat (4) @(negedge clk);
        #2;
        n_checks++;
        if (cyc != 2 || en !== 1'b1) $display("FAIL bad_family: cycles=%0d err=%b required 2,1", cyc, en); else n_pass++;
        n_checks++;
        if (start_cnt - s0 != 0 || done_cnt - d0 != 1 || err !== 1'b1)
            $display("FAIL bad_family_side: starts=%0d dones=%0d err=%b required 0,1,1", start_cnt - s0, done_cnt - d0, err);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int cyc, b, s0;
        logic bn, en, cn;
        b = type_q.size(); s0 = start_cnt;
        run_sweep(3'd1, 1, 3, 0, cyc, bn, en, cn);
        n_checks++;
        if (en !== 1'b0) $display("FAIL to_err_cleared_by_start: got %b required 0", en); else n_pass++;
        n_checks++;
        if (start_cnt - s0 != 9 || cyc != 37) $display("FAIL to_sweep: starts=%0d cycles=%0d required 9,37", start_cnt - s0, cyc); else n_pass++;
        n_checks++;
        if (err_rise_cyc - skip_start_cyc != 9) $display("FAIL to_when: err rose %0d cycles after ISSUE, required 9", err_rise_cyc - skip_start_cyc); else n_pass++;
        n_checks++;
        if (b + 8 < type_q.size() && x_q[b+3] !== 4'd3 || b + 8 < type_q.size() && x_q[b+8] !== 4'd8)
            $display("FAIL to_seq: x3=%0d x8=%0d required 3,8", x_q[b+3], x_q[b+8]);
        else n_pass++;
        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if (err !== 1'b1) $display("FAIL to_sticky: got %b required 1", err); else n_pass++;
        run_sweep(3'd1, 1, 0, 0, cyc, bn, en, cn);
        n_checks++;
        if (en !== 1'b0 || err !== 1'b0) $display("FAIL to_restart_clear: n1=%b end=%b required 0,0", en, err); else n_pass++;
    endtask

    task automatic test_ignored_inputs();
        int cyc, b, s0;
        logic bn, en, cn;
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        #2;
        n_checks++;
        if ({mif.mmu_start_o, ofm_clear, busy, sweep_done} !== 4'd0)
            $display("FAIL idle_done: start,clear,busy,done=%b required 0000", {mif.mmu_start_o, ofm_clear, busy, sweep_done});
        else n_pass++;
        b = type_q.size(); s0 = start_cnt;
        run_sweep(3'd1, 2, 0, 12, cyc, bn, en, cn);
        n_checks++;
        if (start_cnt - s0 != 9 || cyc != 39) $display("FAIL busy_start: starts=%0d cycles=%0d required 9,39", start_cnt - s0, cyc); else n_pass++;
        n_checks++;
        if (b + 8 < type_q.size() && (type_q[b+4] !== 5'd2 || x_q[b+8] !== 4'd8))
            $display("FAIL busy_start_seq: type4=%0d x8=%0d required 2,8", type_q[b+4], x_q[b+8]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc, b, s0, d0;
        logic bn, en, cn;
        d0 = done_cnt;
        resp_lat = 3;
        skip_abs = 0;
        @(negedge clk);
        start_i = 1'b1; family_i = 3'd6;
        @(negedge clk);
        start_i = 1'b0; family_i = 3'd0;
        repeat (8) @(negedge clk);
        resp_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #2;
        n_checks++;
        if ({mif.mmu_start_o, mif.blockX_o, mif.block_type_o, ofm_clear, busy, sweep_done, err} !== 14'd0)
            $display("FAIL rst_mid: outputs=%h required 0", {mif.mmu_start_o, mif.blockX_o, mif.block_type_o, ofm_clear, busy, sweep_done, err});
        else n_pass++;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        n_checks++;
        if (done_cnt != d0 || busy !== 1'b0) $display("FAIL rst_no_done: dones=%0d busy=%b required 0,0", done_cnt - d0, busy); else n_pass++;
        resp_en = 1'b1;
        b = type_q.size(); s0 = start_cnt;
        run_sweep(3'd1, 1, 0, 0, cyc, bn, en, cn);
        n_checks++;
        if (cn !== 1'b1 || start_cnt - s0 != 9 || cyc != 30)
            $display("FAIL rst_restart: clear=%b starts=%0d cycles=%0d required 1,9,30", cn, start_cnt - s0, cyc);
        else n_pass++;
        n_checks++;
        if (b < type_q.size() && (type_q[b] !== 5'd2 || x_q[b] !== 4'd0))
            $display("FAIL rst_first: type=%0d x=%0d required 2,0", type_q[b], x_q[b]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_family_t();
        test_family_o_i();
        test_invalid_family();
        test_timeout();
        test_ignored_inputs();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
